// File: rtl/shifter_pkg.sv
// Types and helpers shared by the shifter word feeder and its FIFO.
package shifter_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } feeder_state_e;

  function automatic int beats_per_word(input int word_width, input int shift_depth);
    return word_width / shift_depth;
  endfunction
endpackage

// File: rtl/sys_structs.sv
// Shared clock-domain bundle: clock, clock enable and a synchronous reset.
package sys_structs;
  typedef struct packed {
    logic clk;
    logic clk_en;
    logic sync_rst;
  } clk_domain;
endpackage

// File: rtl/feeder_fifo.sv
// Purpose: synchronous word FIFO with clear, full/empty flags and occupancy count.
// Latency: a pushed word is visible at the head one cycle after the push.
// Backpressure: push is ignored while full; pop is ignored while empty.
module feeder_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (32'(count) == DEPTH);
  assign empty     = (count == '0);
  assign do_push   = push && !full && !clear;
  assign do_pop    = pop && !empty && !clear;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/shifter_word_feeder.sv
// Purpose: buffers words and paces load/shift/clear strobes for the bit shifter (FEEDER_MSB_FIRST_EN: MSB chunk first).
// Latency: word pushed at edge N is loaded at edge N+1 at the earliest; strobes are registered and clk_en-qualified.
// Backpressure: word_ready_o drops when the FIFO is full; loads wait for shifter_empty_i while idle.
module shifter_word_feeder
  import shifter_pkg::*;
#(
  parameter int WORD_WIDTH  = 16,
  parameter int SHIFT_DEPTH = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int DIV_WIDTH   = 8
) (
  input  sys_structs::clk_domain        clk_dom_i,
  input  logic                          async_rst_i,
  input  logic                          word_valid_i,
  output logic                          word_ready_o,
  input  logic [WORD_WIDTH-1:0]         word_data_i,
  input  logic                          flush_i,
  input  logic [DIV_WIDTH-1:0]          bit_period_i,
  input  logic                          shifter_empty_i,
  output logic                          shifter_we_o,
  output logic                          shifter_shift_o,
  output logic                          shifter_clear_o,
  output logic [WORD_WIDTH-1:0]         shifter_data_o,
  output logic                          word_done_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
  localparam int BEATS = beats_per_word(WORD_WIDTH, SHIFT_DEPTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  if (WORD_WIDTH % SHIFT_DEPTH != 0) begin : g_bad_shift_depth
    $error("WORD_WIDTH must be a multiple of SHIFT_DEPTH");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  logic clk;
  logic en;
  logic unused_sync_rst;
  assign clk             = clk_dom_i.clk;
  assign en              = clk_dom_i.clk_en;
  assign unused_sync_rst = clk_dom_i.sync_rst;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [WORD_WIDTH-1:0] head_data;
  logic [WORD_WIDTH-1:0] ordered_head;

  assign word_ready_o = !fifo_full && !async_rst_i;
  assign fifo_push    = word_valid_i && word_ready_o && en && !flush_i;

  feeder_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (async_rst_i),
    .clear     (en && flush_i),
    .push      (fifo_push),
    .push_data (word_data_i),
    .pop       (fifo_pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_o)
  );

`ifdef FEEDER_MSB_FIRST_EN
  always_comb begin
    ordered_head = '0;
    for (int i = 0; i < BEATS; i++) begin
      ordered_head[i*SHIFT_DEPTH +: SHIFT_DEPTH] = head_data[(BEATS-1-i)*SHIFT_DEPTH +: SHIFT_DEPTH];
    end
  end
`else
  assign ordered_head = head_data;
`endif

  feeder_state_e         state_q, state_d;
  logic [DIV_WIDTH-1:0]  period_q, period_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  we_q, we_d, shift_q, shift_d, clear_q, clear_d, done_q, done_d;
  logic                  take_word;

  always_ff @(posedge clk or posedge async_rst_i) begin
    if (async_rst_i) begin
      state_q  <= IDLE;
      period_q <= '0;
      div_q    <= '0;
      beat_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      shift_q  <= 1'b0;
      clear_q  <= 1'b0;
      done_q   <= 1'b0;
    end else if (en) begin
      state_q  <= state_d;
      period_q <= period_d;
      div_q    <= div_d;
      beat_q   <= beat_d;
      data_q   <= data_d;
      we_q     <= we_d;
      shift_q  <= shift_d;
      clear_q  <= clear_d;
      done_q   <= done_d;
    end
  end

  // The final beat of a word either shifts out (FIFO empty) or is replaced by the next load.
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    div_d     = div_q;
    beat_d    = beat_q;
    data_d    = data_q;
    we_d      = 1'b0;
    shift_d   = 1'b0;
    clear_d   = 1'b0;
    done_d    = 1'b0;
    fifo_pop  = 1'b0;
    take_word = 1'b0;
    if (en) begin
      if (flush_i) begin
        clear_d = 1'b1;
        state_d = IDLE;
        div_d   = '0;
        beat_d  = '0;
      end else begin
        case (state_q)
          IDLE: take_word = !fifo_empty && shifter_empty_i;
          SHIFT: begin
            if (div_q != '0) begin
              div_d = div_q - DIV_WIDTH'(1);
            end else if (beat_q != '0) begin
              shift_d = 1'b1;
              beat_d  = beat_q - BW'(1);
              div_d   = period_q;
            end else if (!fifo_empty) begin
              take_word = 1'b1;
              done_d    = 1'b1;
            end else begin
              shift_d = 1'b1;
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
          default: ;
        endcase
        if (take_word) begin
          we_d     = 1'b1;
          data_d   = ordered_head;
          fifo_pop = 1'b1;
          period_d = bit_period_i;
          div_d    = bit_period_i;
          beat_d   = LAST_BEAT;
          state_d  = SHIFT;
        end
      end
    end
  end

  // Strobes stay registered until the next enabled edge but are only visible while clk_en is high.
  assign shifter_we_o    = we_q && en;
  assign shifter_shift_o = shift_q && en;
  assign shifter_clear_o = clear_q && en;
  assign word_done_o     = done_q && en;
  assign shifter_data_o  = data_q;
  assign busy_o          = (state_q != IDLE);
endmodule

// File: tb/tb_shifter_word_feeder.sv
// Randomized and directed bench for shifter_word_feeder with a timeline reference model and shifter model.
module tb_shifter_word_feeder;
  import sys_structs::*;

  localparam int WW = 8;
  localparam int SD = 1;
  localparam int FD = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic rst = 1'b1;
  clk_domain cd;
  assign cd = {clk, clk_en, 1'b0};

  logic          word_valid = 1'b0;
  logic          flush = 1'b0;
  logic [WW-1:0] word_data = '0;
  logic [DW-1:0] bit_period = '0;
  logic          word_ready, sh_empty, we, shift, clear, done, busy;
  logic [WW-1:0] sdata;
  logic [$clog2(FD):0] fcount;

  shifter_word_feeder #(.WORD_WIDTH(WW), .SHIFT_DEPTH(SD), .FIFO_DEPTH(FD), .DIV_WIDTH(DW)) dut (
    .clk_dom_i       (cd),
    .async_rst_i     (rst),
    .word_valid_i    (word_valid),
    .word_ready_o    (word_ready),
    .word_data_i     (word_data),
    .flush_i         (flush),
    .bit_period_i    (bit_period),
    .shifter_empty_i (sh_empty),
    .shifter_we_o    (we),
    .shifter_shift_o (shift),
    .shifter_clear_o (clear),
    .shifter_data_o  (sdata),
    .word_done_o     (done),
    .busy_o          (busy),
    .fifo_count_o    (fcount)
  );

  always #5 clk = ~clk;

  // Downstream shifter: bits remaining; empty when none left.
  int rem = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) rem <= 0;
    else if (clk_en) begin
      if (clear) rem <= 0;
      else if (we) rem <= WW / SD;
      else if (shift && rem > 0) rem <= rem - 1;
    end
  end
  assign sh_empty = (rem == 0);

  typedef struct { int kind; logic [WW-1:0] dat; int t; } ev_t;  // kind: 0 we, 1 shift, 2 clear, 3 done
  ev_t ev_q[$];
  int acc_t[$];
  logic [WW-1:0] acc_d[$];
  logic [WW-1:0] wq[$];
  int en_t = 0, en0_bad = 0, multi_bad = 0;
  int total = 0, bad = 0, full_seen = 0;
  bit gate = 1'b0;

  always @(posedge clk) begin
    if (clk_en) begin
      en_t++;
      if (word_valid && word_ready && !flush) begin
        acc_t.push_back(en_t);
        acc_d.push_back(word_data);
      end
      if (we)    ev_q.push_back('{0, sdata, en_t});
      if (shift) ev_q.push_back('{1, '0, en_t});
      if (clear) ev_q.push_back('{2, '0, en_t});
      if (done)  ev_q.push_back('{3, '0, en_t});
    end else if (we || shift || clear || done) en0_bad++;
    if (int'(we) + int'(shift) + int'(clear) > 1) multi_bad++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clk_en = gate ? ~clk_en : 1'b1;
  endtask

  function automatic logic [WW-1:0] exp_data(input logic [WW-1:0] w);
`ifdef FEEDER_MSB_FIRST_EN
    return {<<{w}};
`else
    return w;
`endif
  endfunction

  function automatic int count_kind(input int k);
    int c = 0;
    foreach (ev_q[j]) if (ev_q[j].kind == k) c++;
    return c;
  endfunction

  task automatic push_words();
    for (int i = 0; i < wq.size(); i++) begin
      int sz = acc_t.size();
      word_valid = 1'b1;
      word_data  = wq[i];
      for (int c = 0; c < 400 && acc_t.size() == sz; c++) begin
        step();
        if (fcount == FD) begin
          full_seen++;
          chk("ready_when_full", word_ready, 0);
        end
      end
      chk("push_accept", acc_t.size() > sz, 1);
    end
    word_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while (c < 4000 && (busy || fcount != 0 || !sh_empty)) begin
      step();
      c++;
    end
    chk("drain_idle", busy || fcount != 0 || !sh_empty, 0);
    repeat (4) step();
  endtask

  // Each word: load at its start, shifts every p+1 enabled cycles, and an 8th event that is
  // either the next word's load (if it was buffered in time) or a final shift.
  task automatic check_model(input int p);
    ev_t exp_q[$];
    int e, f, m;
    f = 0;
    for (int i = 0; i < acc_t.size(); i++) begin
      if (i > 0 && acc_t[i] <= f - 2) begin
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        e = f;
        exp_q.push_back('{0, exp_data(acc_d[i]), e});
        exp_q.push_back('{3, '0, e});
      end else begin
        e = ((i > 0 && f > acc_t[i]) ? f : acc_t[i]) + 2;
        exp_q.push_back('{0, exp_data(acc_d[i]), e});
      end
      for (int k = 1; k < WW / SD; k++) exp_q.push_back('{1, '0, e + k * (p + 1)});
      f = e + (WW / SD) * (p + 1);
      exp_q.push_back('{1, '0, f});
      exp_q.push_back('{3, '0, f});
    end
    chk("ev_count", ev_q.size(), exp_q.size());
    m = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
    for (int j = 0; j < m; j++) begin
      chk("ev_kind", ev_q[j].kind, exp_q[j].kind);
      chk("ev_time", ev_q[j].t, exp_q[j].t);
      if (exp_q[j].kind == 0) chk("ev_data", ev_q[j].dat, exp_q[j].dat);
    end
  endtask

  task automatic run_burst(input int p, input bit chg);
    ev_q.delete();
    acc_t.delete();
    acc_d.delete();
    bit_period = DW'(p);
    push_words();
    if (chg) begin
      for (int c = 0; c < 100 && count_kind(0) == 0; c++) step();
      bit_period = 8'd5;
    end
    drain();
    check_model(p);
    bit_period = DW'(p);
  endtask

  initial begin
    int d0, d1, ft, n;
    #2;
    chk("rst_we", we, 0);
    chk("rst_shift", shift, 0);
    chk("rst_clear", clear, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", fcount, 0);
    chk("rst_ready", word_ready, 0);
    chk("rst_data", sdata, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("ready_after_rst", word_ready, 1);

    // single word, period 0
    wq = {8'hA5};
    run_burst(0, 1'b0);
    if (ev_q.size() > 0 && acc_t.size() > 0) chk("load_latency", ev_q[0].t - acc_t[0], 2);
    chk("single_done", count_kind(3), 1);
    chk("single_busy", busy, 0);

    // period change mid-word is ignored
    wq = {8'h5A};
    run_burst(1, 1'b1);

    // back-to-back words, period 2
    wq = {8'h0F, 8'hF0};
    run_burst(2, 1'b0);
    d0 = -1; d1 = -1;
    foreach (ev_q[j]) if (ev_q[j].kind == 3) begin
      if (d0 < 0) d0 = ev_q[j].t; else d1 = ev_q[j].t;
    end
    chk("b2b_done_gap", d1 - d0, 24);

    // backpressure: one word occupies the shifter, five more overfill the FIFO
    full_seen = 0;
    wq = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_burst(1, 1'b0);
    chk("bp_full_seen", full_seen > 0, 1);
    if (acc_t.size() == 6) chk("bp_late_accept", acc_t[5] - acc_t[0], 2 + 8 * 2);

    // clk_en gating
    gate = 1'b1;
    wq = {8'hC3, 8'h96};
    run_burst(0, 1'b0);
    gate = 1'b0;
    step();

    // flush at beat 3 with two words queued
    ev_q.delete(); acc_t.delete(); acc_d.delete();
    bit_period = 8'd0;
    wq = {8'h12, 8'h34, 8'h56};
    push_words();
    for (int c = 0; c < 200 && count_kind(1) < 3; c++) step();
    chk("flush_beat3", count_kind(1), 3);
    chk("flush_queued", fcount, 2);
    flush = 1'b1;
    word_valid = 1'b1;
    word_data = 8'h77;
    step();
    ft = en_t;
    flush = 1'b0;
    word_valid = 1'b0;
    repeat (4) step();
    chk("flush_clear_cnt", count_kind(2), 1);
    foreach (ev_q[j]) if (ev_q[j].kind == 2) chk("flush_clear_t", ev_q[j].t, ft + 1);
    chk("flush_no_done", count_kind(3), 0);
    chk("flush_count", fcount, 0);
    chk("flush_busy", busy, 0);
    n = 0;
    foreach (ev_q[j]) if (ev_q[j].kind == 0 && ev_q[j].t > ft) n++;
    chk("flush_no_load", n, 0);

    // async reset mid-word
    ev_q.delete(); acc_t.delete(); acc_d.delete();
    bit_period = 8'd1;
    wq = {8'h3C};
    push_words();
    for (int c = 0; c < 200 && count_kind(1) < 2; c++) step();
    chk("arst_mid_word", busy, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_we", we, 0);
    chk("arst_shift", shift, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", fcount, 0);
    chk("arst_ready", word_ready, 0);
    chk("arst_data", sdata, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    wq = {8'h3C};
    run_burst(1, 1'b0);

    // randomized bursts
    for (int r = 0; r < 6; r++) begin
      int nw = $urandom_range(1, 6);
      int p = $urandom_range(0, 3);
      gate = r[0];
      wq.delete();
      for (int i = 0; i < nw; i++) wq.push_back(WW'($urandom));
      run_burst(p, 1'b0);
      gate = 1'b0;
      step();
    end

    chk("strobe_while_en0", en0_bad, 0);
    chk("multi_strobe", multi_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
